// File: rtl/byte_mem_pkg.sv
// rtl/byte_mem_pkg.sv - shared state encoding and byte address helper for byte_mem_ctrl
package byte_mem_pkg;

    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_READY = 1'b1;

    // (base + k) truncated to addr_w bits; gives modulo wrap across the top of memory
    function automatic logic [31:0] byte_addr(input logic [31:0] base,
                                              input logic [31:0] k,
                                              input int unsigned addr_w);
        logic [31:0] mask;
        mask = (32'd1 << addr_w) - 32'd1;
        return (base + k) & mask;
    endfunction

endpackage

// File: rtl/byte_mem_rd_pipe.sv
// rtl/byte_mem_rd_pipe.sv - LAT-deep {valid, data} read response pipeline
module byte_mem_rd_pipe #(
    parameter int W   = 32,
    parameter int LAT = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o
);

    logic [LAT-1:0] vld_q;
    logic [W-1:0]   dat_q [LAT];

    // Data only advances behind a valid bit, so the last stage holds the previous read
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
        end else begin
            vld_q[0] <= in_valid_i;
            if (in_valid_i) dat_q[0] <= in_data_i;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_valid_o = vld_q[LAT-1];
    assign out_data_o  = dat_q[LAT-1];

endmodule

// File: rtl/byte_mem_ctrl.sv
// rtl/byte_mem_ctrl.sv - byte-addressed big-endian word memory with clear sweep and pipelined reads
module byte_mem_ctrl
    import byte_mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int BYTES  = 4,
    parameter int RD_LAT = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 rw_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [8*BYTES-1:0]   din_i,
    input  logic [BYTES-1:0]     be_i,
    output logic [8*BYTES-1:0]   d_out_o,
    output logic                 rsp_valid_o,
    output logic                 busy_o
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int DW    = 8*BYTES;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - BYTES);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(BYTES);

    logic              state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              clear_en;
    logic              wr_acc, rd_acc;
    logic [DW-1:0]     rd_word;
    logic [7:0]        mem [0:DEPTH-1];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + STEP;
                if (ptr_q == LAST_PTR) state_d = ST_READY;
            end
            default: state_d = ST_READY;
        endcase
    end

    always_comb begin
        clear_en    = (state_q == ST_CLEAR);
        busy_o      = (state_q == ST_CLEAR);
        req_ready_o = (state_q == ST_READY);
    end

    assign wr_acc = req_valid_i && req_ready_o && rw_i;
    assign rd_acc = req_valid_i && req_ready_o && !rw_i;

    // Array has no reset; the sweep zeroes it one word-group per cycle
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < BYTES; k++) begin
            if (clear_en)
                mem[ADDR_W'(byte_addr(32'(ptr_q), 32'(k), ADDR_W))] <= 8'h00;
            else if (wr_acc && be_i[BYTES-1-k])
                mem[ADDR_W'(byte_addr(32'(addr_i), 32'(k), ADDR_W))] <= din_i[8*(BYTES-k)-1 -: 8];
        end
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < BYTES; k++)
            rd_word[8*(BYTES-k)-1 -: 8] = mem[ADDR_W'(byte_addr(32'(addr_i), 32'(k), ADDR_W))];
    end

    byte_mem_rd_pipe #(
        .W   (DW),
        .LAT (RD_LAT)
    ) u_rd_pipe (
        .clk_i       (clk_i),
        .rst_i       (reset_i),
        .in_valid_i  (rd_acc),
        .in_data_i   (rd_word),
        .out_valid_o (rsp_valid_o),
        .out_data_o  (d_out_o)
    );

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// tb/tb_byte_mem_ctrl.sv - self-checking bench for byte_mem_ctrl against a byte-array model
module tb_byte_mem_ctrl;

    localparam int RD_LAT = 3;
    localparam int PER    = 10;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        rw_i = 1'b0;
    logic [7:0]  addr_i = '0;
    logic [31:0] din_i = '0;
    logic [3:0]  be_i = '0;
    logic [31:0] d_out_o;
    logic        rsp_valid_o;
    logic        busy_o;

    byte_mem_ctrl #(.ADDR_W(8), .BYTES(4), .RD_LAT(RD_LAT)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .rw_i        (rw_i),
        .addr_i      (addr_i),
        .din_i       (din_i),
        .be_i        (be_i),
        .d_out_o     (d_out_o),
        .rsp_valid_o (rsp_valid_o),
        .busy_o      (busy_o)
    );

    always #(PER/2) clk = ~clk;

    typedef struct { logic [31:0] d; int cnt; } pend_t;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  mm [256];
    pend_t       pq [$];
    logic [31:0] model_dout = '0;
    int          rsp_cnt = 0;
    logic [31:0] got_d [$];
    time         got_t [$];
    time         t_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*(4-k)-1 -: 8] = mm[8'(a + 8'(k))];
        return w;
    endfunction

    // Responses leave in order; each one surfaces RD_LAT sample points after its accept edge
    initial begin
        forever begin
            logic exp_v;
            pend_t e;
            @(negedge clk);
            #1;
            foreach (pq[i]) pq[i].cnt--;
            exp_v = 1'b0;
            if (pq.size() > 0 && pq[0].cnt == 0) begin
                exp_v = 1'b1;
                e = pq.pop_front();
                model_dout = e.d;
                rsp_cnt++;
                got_d.push_back(d_out_o);
                got_t.push_back($time);
            end
            chk("rsp_valid", 32'(rsp_valid_o), 32'(exp_v));
            chk("d_out", d_out_o, model_dout);
        end
    end

    task automatic req(input logic rw, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        req_valid_i = 1'b1;
        rw_i = rw;
        addr_i = a;
        din_i = d;
        be_i = be;
        @(posedge clk);
        t_acc = $time;
        if (rw) begin
            for (int k = 0; k < 4; k++)
                if (be[3-k]) mm[8'(a + 8'(k))] = d[8*(4-k)-1 -: 8];
        end else begin
            pq.push_back('{d: model_read(a), cnt: RD_LAT});
        end
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    task automatic expect_read(input string name, input logic [7:0] a, input logic [31:0] exp);
        int c0;
        int n;
        c0 = rsp_cnt;
        req(1'b0, a, '0, '0);
        #2;
        n = 0;
        while (rsp_cnt == c0 && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk({name, "_timeout"}, 32'(rsp_cnt == c0), 32'd0);
        chk(name, d_out_o, exp);
    endtask

    task automatic release_and_sweep();
        int n;
        logic rdy_seen;
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        n = 0;
        rdy_seen = 1'b0;
        while (busy_o && n < 300) begin
            if (req_ready_o) rdy_seen = 1'b1;
            @(negedge clk);
            #1;
            n++;
        end
        chk("clear_cycles", 32'(n), 32'd64);
        chk("ready_during_clear", 32'(rdy_seen), 32'd0);
        chk("ready_after_clear", 32'(req_ready_o), 32'd1);
        chk("busy_after_clear", 32'(busy_o), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        foreach (mm[i]) mm[i] = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", 32'(busy_o), 32'd1);
        chk("reset_ready", 32'(req_ready_o), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("reset_d_out", d_out_o, 32'd0);

        // 1: sweep length and cleared contents
        release_and_sweep();
        expect_read("rd_00_clear", 8'h00, 32'h0000_0000);
        expect_read("rd_fc_clear", 8'hFC, 32'h0000_0000);

        // 2: aligned and unaligned read of a full word
        req(1'b1, 8'h00, 32'hACBD4432, 4'hF);
        expect_read("rd_00", 8'h00, 32'hACBD4432);
        expect_read("rd_01", 8'h01, 32'hBD443200);

        // 3: wrap across the top of memory
        req(1'b1, 8'hFE, 32'hDFD6BB42, 4'hF);
        expect_read("rd_fe_wrap", 8'hFE, 32'hDFD6BB42);
        expect_read("rd_00_wrap", 8'h00, 32'hBB424432);

        // 4: partial byte enables, and BE=0 no-op
        req(1'b1, 8'h04, 32'h11223344, 4'hF);
        req(1'b1, 8'h04, 32'hAAAAAAAA, 4'b0101);
        expect_read("rd_04_be", 8'h04, 32'h11AA33AA);
        req(1'b1, 8'h04, 32'hFFFFFFFF, 4'h0);
        expect_read("rd_04_be0", 8'h04, 32'h11AA33AA);

        // write immediately followed by an overlapping read
        req(1'b1, 8'h0A, 32'h5566_7788, 4'hF);
        expect_read("rd_after_wr", 8'h08, 32'h0000_5566);

        // 5: four back-to-back reads at RD_LAT=3
        got_d.delete();
        got_t.delete();
        req(1'b0, 8'h00, '0, '0);
        begin
            time t_first;
            t_first = t_acc;
            req(1'b0, 8'h04, '0, '0);
            req(1'b0, 8'h08, '0, '0);
            req(1'b0, 8'h0C, '0, '0);
            repeat (RD_LAT + 2) @(negedge clk);
            #2;
            chk("b2b_count", 32'(got_d.size()), 32'd4);
            if (got_d.size() == 4) begin
                chk("b2b_first_time", 32'(got_t[0] - t_first), 32'(2*PER + PER/2 + 1));
                for (int i = 1; i < 4; i++)
                    chk("b2b_spacing", 32'(got_t[i] - got_t[i-1]), 32'(PER));
                chk("b2b_d0", got_d[0], 32'hBB424432);
                chk("b2b_d1", got_d[1], 32'h11AA33AA);
                chk("b2b_d2", got_d[2], 32'h0000_5566);
                chk("b2b_d3", got_d[3], 32'h7788_0000);
            end
        end

        // 6: reset with two reads in flight
        expect_read("rd_04_pre_reset", 8'h04, 32'h11AA33AA);
        req(1'b0, 8'h00, '0, '0);
        req(1'b0, 8'h04, '0, '0);
        reset_i = 1'b1;
        pq.delete();
        model_dout = '0;
        foreach (mm[i]) mm[i] = 8'h00;
        #1;
        chk("flush_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("flush_d_out", d_out_o, 32'd0);
        chk("flush_busy", 32'(busy_o), 32'd1);
        repeat (2) @(negedge clk);
        release_and_sweep();
        expect_read("rd_04_recleared", 8'h04, 32'h0000_0000);
        expect_read("rd_fe_recleared", 8'hFE, 32'h0000_0000);

        repeat (4) @(negedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
